grid_target_game: RTL

Parametrised reaction game engine for the RGB LED matrix. It places a pseudo-random coloured target on a ROWS×COLS grid and scores player hits made with a cursor and hit button. Misses accumulate on wrong hits and on target timeouts, and play ends at a miss limit. It drives the per-pixel colour vectors consumed by the matrix scan driver and generates its own game tick from the system clock.

---
 rtl/grid_target_game.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/grid_target_game.sv
// Reaction game engine for the RGB LED matrix: spawns LCG-placed coloured targets,
// scores cursor hits, counts misses and drives registered per-pixel colour vectors.
module grid_target_game #(
  parameter int unsigned ROWS           = 8,
  parameter int unsigned COLS           = 8,
  parameter int unsigned COLOR_BITS     = 4,
  parameter int unsigned TICK_DIV       = 50_000_000,
  parameter int unsigned LIFETIME_TICKS = 4,
  parameter int unsigned MAX_MISSES     = 3,
  parameter logic [31:0] SEED           = 32'h0000_0001
) (
  input  logic                              CLK100MHZ,
  input  logic                              i_rst_n,
  input  logic                              i_start,
  input  logic                              i_hit,
  input  logic [$clog2(ROWS)-1:0]           i_cursor_row,
  input  logic [$clog2(COLS)-1:0]           i_cursor_col,
  output logic [ROWS*COLS*COLOR_BITS-1:0]   o_red,
  output logic [ROWS*COLS*COLOR_BITS-1:0]   o_green,
  output logic [ROWS*COLS*COLOR_BITS-1:0]   o_blue,
  output logic [15:0]                       o_score,
  output logic [7:0]                        o_misses,
  output logic                              o_game_over
);

  localparam int unsigned NPIX   = ROWS * COLS;
  localparam int unsigned PIX_W  = $clog2(NPIX);
  localparam int unsigned VEC_W  = NPIX * COLOR_BITS;
  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned LIFE_W = $clog2(LIFETIME_TICKS + 1);

  localparam logic [COLOR_BITS-1:0] FULL = {COLOR_BITS{1'b1}};
  localparam logic [COLOR_BITS-1:0] DIM  = COLOR_BITS'(1) << (COLOR_BITS - 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SPAWN  = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_FLASH  = 3'd3;
  localparam logic [2:0] S_OVER   = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [31:0]       r;
  logic [31:0]       r_nxt;
  logic [PIX_W-1:0]  target;
  logic [PIX_W-1:0]  spawn_pos;
  logic [1:0]        color;
  logic [LIFE_W-1:0] life;
  logic [TICK_W-1:0] tick_cnt;
  logic [31:0]       cur_pix;
  logic              cur_in_range;
  logic              tick, expire, hit_ok, wrong_hit, misses_last;
  logic              score_inc, miss_inc, clr_counters;
  logic [VEC_W-1:0]  red_c, green_c, blue_c;

  assign r_nxt     = r * 32'd1664525 + 32'd1013904223;
  assign spawn_pos = PIX_W'((48'(r_nxt[31:16]) * 48'(NPIX)) >> 16);

  assign cur_pix      = 32'(i_cursor_row) * COLS + 32'(i_cursor_col);
  assign cur_in_range = (32'(i_cursor_row) < ROWS) && (32'(i_cursor_col) < COLS);

  assign tick        = ((state == S_ACTIVE) || (state == S_FLASH)) &&
                       (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign expire      = tick && (life == LIFE_W'(1));
  assign hit_ok      = i_hit && cur_in_range && (cur_pix == 32'(target));
  assign wrong_hit   = i_hit && !hit_ok;
  assign misses_last = ({1'b0, o_misses} + 9'd1) == 9'(MAX_MISSES);

  // Next-state and control strobes; a matching hit outranks a simultaneous expiry
  always_comb begin
    state_nxt    = state;
    score_inc    = 1'b0;
    miss_inc     = 1'b0;
    clr_counters = 1'b0;
    case (state)
      S_IDLE, S_OVER: begin
        if (i_start) begin
          state_nxt    = S_SPAWN;
          clr_counters = 1'b1;
        end
      end
      S_SPAWN: state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (hit_ok) begin
          score_inc = 1'b1;
          state_nxt = S_FLASH;
        end else if (wrong_hit || expire) begin
          miss_inc = 1'b1;
          if (misses_last)  state_nxt = S_OVER;
          else if (expire)  state_nxt = S_SPAWN;
        end
      end
      S_FLASH: if (tick) state_nxt = S_SPAWN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Target, lifetime, tick divider and score/miss counters
  always_ff @(posedge CLK100MHZ or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r           <= SEED;
      target      <= '0;
      color       <= '0;
      life        <= '0;
      tick_cnt    <= '0;
      o_score     <= '0;
      o_misses    <= '0;
      o_game_over <= 1'b0;
    end else begin
      if (state == S_SPAWN) begin
        r      <= r_nxt;
        target <= spawn_pos;
        color  <= r_nxt[15:14];
        life   <= LIFE_W'(LIFETIME_TICKS);
      end else if ((state == S_ACTIVE) && tick) begin
        life <= life - LIFE_W'(1);
      end

      if (((state == S_ACTIVE) || (state == S_FLASH)) && (state_nxt == state))
        tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
      else
        tick_cnt <= '0;

      if (clr_counters)                        o_score <= '0;
      else if (score_inc && (o_score != 16'hFFFF)) o_score <= o_score + 16'd1;

      if (clr_counters)  o_misses <= '0;
      else if (miss_inc) o_misses <= o_misses + 8'd1;

      o_game_over <= (state_nxt == S_OVER);
    end
  end

  // Frame content for the current state; registered below so it lags by one cycle
  always_comb begin
    red_c   = '0;
    green_c = '0;
    blue_c  = '0;
    for (int unsigned p = 0; p < NPIX; p++) begin
      case (state)
        S_ACTIVE: begin
          if (p == 32'(target)) begin
            if ((color == 2'd0) || (color == 2'd3)) red_c[p*COLOR_BITS +: COLOR_BITS]   = FULL;
            if ((color == 2'd1) || (color == 2'd3)) green_c[p*COLOR_BITS +: COLOR_BITS] = FULL;
            if ((color == 2'd2) || (color == 2'd3)) blue_c[p*COLOR_BITS +: COLOR_BITS]  = FULL;
          end else if (cur_in_range && (p == cur_pix)) begin
            blue_c[p*COLOR_BITS +: COLOR_BITS] = DIM;
          end
        end
        S_FLASH: begin
          if (p == 32'(target)) begin
            red_c[p*COLOR_BITS +: COLOR_BITS]   = FULL;
            green_c[p*COLOR_BITS +: COLOR_BITS] = FULL;
            blue_c[p*COLOR_BITS +: COLOR_BITS]  = FULL;
          end
        end
        S_OVER: red_c[p*COLOR_BITS +: COLOR_BITS] = FULL;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
    end else begin
      o_red   <= red_c;
      o_green <= green_c;
      o_blue  <= blue_c;
    end
  end

endmodule
